// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the IF/ID pipeline-control slice.
//   - pipe_state_t : sequencing states of the IF/ID / PC controller
//   - ctrl_t       : bundle of the five pipeline-control strobes
//   - XZR          : register number that never creates a dependency
//   - clamp_flush_cycles : bounds the flush-length parameter to 1..7
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_FREEZE = 2'd2
  } pipe_state_t;

  // Control strobes, packed so whole output patterns can be named once.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic pipe_freeze;
  } ctrl_t;

  localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b1, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_FLUSH  = '{pc_write: 1'b1, if_id_write: 1'b1, if_id_flush: 1'b1,
                                    id_ex_bubble: 1'b0, pipe_freeze: 1'b0};
  localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, if_id_write: 1'b0, if_id_flush: 1'b0,
                                    id_ex_bubble: 1'b0, pipe_freeze: 1'b1};

  localparam logic [4:0] XZR = 5'd31;

  localparam int FLUSH_MIN   = 1;
  localparam int FLUSH_MAX   = 7;
  localparam int FLUSH_CNT_W = 3;   // holds FLUSH_MAX-1

  // Keeps an out-of-range flush length from wrapping the 3-bit counter.
  function automatic int clamp_flush_cycles(input int n);
    if (n < FLUSH_MIN)      return FLUSH_MIN;
    else if (n > FLUSH_MAX) return FLUSH_MAX;
    else                    return n;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use comparator: flags when the load currently in EX writes a
// register that the instruction in ID reads. X31 (XZR) never hazards.
// Purely combinational so a forwarding unit can reuse it.
// Ports:
//   ex_mem_read, ex_Rd        : EX-stage load flag and destination
//   id_Rn/Rm/Rd, id_uses_*    : ID-stage source fields and read enables
//   load_use                  : 1 when ID must wait one cycle for the load
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic       ex_mem_read,
  input  logic [4:0] ex_Rd,
  input  logic [4:0] id_Rn,
  input  logic [4:0] id_Rm,
  input  logic [4:0] id_Rd,
  input  logic       id_uses_rn,
  input  logic       id_uses_rm,
  input  logic       id_uses_rd,
  output logic       load_use
);

  logic hit_rn;
  logic hit_rm;
  logic hit_rd;

  assign hit_rn = id_uses_rn && (ex_Rd == id_Rn);
  assign hit_rm = id_uses_rm && (ex_Rd == id_Rm);
  // Rd/Rt is a source for stores and CBZ, hence a third comparison.
  assign hit_rd = id_uses_rd && (ex_Rd == id_Rd);

  assign load_use = ex_mem_read && (ex_Rd != XZR) && (hit_rn || hit_rm || hit_rd);

endmodule

// File: rtl/if_id_hazard_ctrl.sv
// IF/ID and PC sequencing controller.
// Resolves, in priority order, data-memory freezes, load-use stalls and
// taken-branch flushes, and counts the cycles in which the PC is held.
// All control outputs are combinational from the state and the current
// inputs, so the pipeline reacts in the same cycle.
// Ports:
//   clk, reset (async, active-low)
//   id_Rn/Rm/Rd, id_uses_*      : ID-stage operand fields
//   ex_mem_read, ex_Rd          : EX-stage load information
//   br_taken                    : branch resolved taken in ID
//   mem_busy                    : data memory access still pending
//   pc_write, if_id_write       : PC / IF-ID load enables
//   IF_ID_flush                 : clear IF/ID at the next rising edge
//   id_ex_bubble                : zero the ID/EX control bits
//   pipe_freeze                 : hold ID/EX, EX/MEM, MEM/WB
//   stall_count                 : saturating count of pc_write=0 cycles
module if_id_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_Rn,
  input  logic [4:0]       id_Rm,
  input  logic [4:0]       id_Rd,
  input  logic             id_uses_rn,
  input  logic             id_uses_rm,
  input  logic             id_uses_rd,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_Rd,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             IF_ID_flush,
  output logic             id_ex_bubble,
  output logic             pipe_freeze,
  output logic [CNT_W-1:0] stall_count
);

  localparam int                     FC_EFF       = clamp_flush_cycles(FLUSH_CYCLES);
  localparam logic [FLUSH_CNT_W-1:0] FLUSH_RELOAD = FLUSH_CNT_W'(FC_EFF - 1);

  pipe_state_t            state_q, state_d;
  pipe_state_t            ret_q, ret_d;       // state to resume after FREEZE
  pipe_state_t            eval_state;
  logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic                   load_use;
  ctrl_t                  ctrl;

  hazard_detect u_hazard_detect (
    .ex_mem_read (ex_mem_read),
    .ex_Rd       (ex_Rd),
    .id_Rn       (id_Rn),
    .id_Rm       (id_Rm),
    .id_Rd       (id_Rd),
    .id_uses_rn  (id_uses_rn),
    .id_uses_rm  (id_uses_rm),
    .id_uses_rd  (id_uses_rd),
    .load_use    (load_use)
  );

  // Next-state and output decode.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    ret_d       = ret_q;
    flush_cnt_d = flush_cnt_q;
    ctrl        = CTRL_RUN;

    // Leaving FREEZE evaluates the saved state's rules in the same cycle.
    eval_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    if (mem_busy) begin
      ctrl    = CTRL_FREEZE;
      state_d = ST_FREEZE;
      // Only capture the return state on entry; the flush counter is kept.
      if (state_q != ST_FREEZE) ret_d = state_q;
    end else begin
      ret_d = ST_RUN;
      case (eval_state)
        ST_FLUSH: begin
          // ID holds a bubble, so load_use and br_taken are irrelevant here.
          ctrl        = CTRL_FLUSH;
          flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
          state_d     = (flush_cnt_q <= FLUSH_CNT_W'(1)) ? ST_RUN : ST_FLUSH;
        end
        default: begin
          state_d = ST_RUN;
          if (load_use) begin
            // The branch operand may be the loaded value, so the branch
            // waits; the stall ends by itself as the load leaves EX.
            ctrl = CTRL_STALL;
          end else if (br_taken) begin
            ctrl = CTRL_FLUSH;
            if (FC_EFF > 1) begin
              state_d     = ST_FLUSH;
              flush_cnt_d = FLUSH_RELOAD;
            end
          end
        end
      endcase
    end

    // Outputs take their safe values the moment reset asserts, without
    // waiting for a clock edge.
    if (!reset) ctrl = CTRL_RESET;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      ret_q       <= ST_RUN;
      flush_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the
      // pre-edge values, independent of statement order.
      state_q     <= state_d;
      ret_q       <= ret_d;
      flush_cnt_q <= flush_cnt_d;
      if (!ctrl.pc_write && (stall_cnt_q != '1)) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
    end
  end

  assign pc_write     = ctrl.pc_write;
  assign if_id_write  = ctrl.if_id_write;
  assign IF_ID_flush  = ctrl.if_id_flush;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign pipe_freeze  = ctrl.pipe_freeze;
  assign stall_count  = stall_cnt_q;

endmodule

// File: tb/tb_if_id_hazard_ctrl.sv
// Bench for if_id_hazard_ctrl. Two instances share the stimulus:
//   dut_a : FLUSH_CYCLES=2, CNT_W=16
//   dut_b : FLUSH_CYCLES=3, CNT_W=3 (reaches counter saturation quickly)
// A rule-level model (remaining flush cycles + stall tally) predicts all
// outputs and is compared at every falling edge; directed sections add
// hand-computed literal checks.
module tb_if_id_hazard_ctrl;

  localparam int FC_A = 2;
  localparam int FC_B = 3;
  localparam int CW_A = 16;
  localparam int CW_B = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_Rn, id_Rm, id_Rd, ex_Rd;
  logic       id_uses_rn, id_uses_rm, id_uses_rd;
  logic       ex_mem_read, br_taken, mem_busy;

  logic            pc_write_a, if_id_write_a, flush_a, bubble_a, freeze_a;
  logic [CW_A-1:0] stall_count_a;
  logic            pc_write_b, if_id_write_b, flush_b, bubble_b, freeze_b;
  logic [CW_B-1:0] stall_count_b;

  int total = 0;
  int bad   = 0;
  int sc0;

  always #5 clk = ~clk;

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC_A), .CNT_W(CW_A)) dut_a (
    .clk(clk), .reset(reset),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd),
    .ex_mem_read(ex_mem_read), .ex_Rd(ex_Rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_write(pc_write_a), .if_id_write(if_id_write_a), .IF_ID_flush(flush_a),
    .id_ex_bubble(bubble_a), .pipe_freeze(freeze_a), .stall_count(stall_count_a)
  );

  if_id_hazard_ctrl #(.FLUSH_CYCLES(FC_B), .CNT_W(CW_B)) dut_b (
    .clk(clk), .reset(reset),
    .id_Rn(id_Rn), .id_Rm(id_Rm), .id_Rd(id_Rd),
    .id_uses_rn(id_uses_rn), .id_uses_rm(id_uses_rm), .id_uses_rd(id_uses_rd),
    .ex_mem_read(ex_mem_read), .ex_Rd(ex_Rd), .br_taken(br_taken), .mem_busy(mem_busy),
    .pc_write(pc_write_b), .if_id_write(if_id_write_b), .IF_ID_flush(flush_b),
    .id_ex_bubble(bubble_b), .pipe_freeze(freeze_b), .stall_count(stall_count_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Any listed source register equal to the load destination, X31 excluded.
  function automatic logic model_lu(input logic rd_en, input logic [4:0] dst,
                                    input logic [4:0] rn, input logic [4:0] rm,
                                    input logic [4:0] rd, input logic urn,
                                    input logic urm, input logic urd);
    logic [4:0] src [3];
    logic       en  [3];
    logic       hit;
    src = '{rn, rm, rd};
    en  = '{urn, urm, urd};
    hit = 1'b0;
    for (int i = 0; i < 3; i++) if (en[i] && src[i] == dst) hit = 1'b1;
    return rd_en && (dst != 5'd31) && hit;
  endfunction

  // Expected {pc_write, if_id_write, IF_ID_flush, id_ex_bubble, pipe_freeze}
  // given how many flush cycles remain owed after the branch cycle.
  function automatic logic [4:0] model_ctrl(input int flush_left, input logic rst,
                                            input logic busy, input logic lu,
                                            input logic br);
    if (!rst)               return 5'b00110;
    else if (busy)          return 5'b00001;
    else if (flush_left > 0) return 5'b11100;
    else if (lu)            return 5'b00010;
    else if (br)            return 5'b11100;
    else                    return 5'b11000;
  endfunction

  int         fl_a = 0, fl_b = 0, cnt_a = 0, cnt_b = 0;
  logic       m_lu;
  logic [4:0] exp_a, exp_b;

  always_comb begin
    m_lu  = model_lu(ex_mem_read, ex_Rd, id_Rn, id_Rm, id_Rd, id_uses_rn, id_uses_rm, id_uses_rd);
    exp_a = model_ctrl(fl_a, reset, mem_busy, m_lu, br_taken);
    exp_b = model_ctrl(fl_b, reset, mem_busy, m_lu, br_taken);
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      fl_a <= 0; fl_b <= 0; cnt_a <= 0; cnt_b <= 0;
    end else begin
      if (!exp_a[4] && cnt_a < (1 << CW_A) - 1) cnt_a <= cnt_a + 1;
      if (!exp_b[4] && cnt_b < (1 << CW_B) - 1) cnt_b <= cnt_b + 1;
      if (!mem_busy) begin
        if (fl_a > 0) fl_a <= fl_a - 1;
        else if (!m_lu && br_taken) fl_a <= FC_A - 1;
        if (fl_b > 0) fl_b <= fl_b - 1;
        else if (!m_lu && br_taken) fl_b <= FC_B - 1;
      end
    end
  end

  // Single compare process: every falling edge, both instances.
  always @(negedge clk) begin
    check("ctrl_a", {27'd0, pc_write_a, if_id_write_a, flush_a, bubble_a, freeze_a}, {27'd0, exp_a});
    check("ctrl_b", {27'd0, pc_write_b, if_id_write_b, flush_b, bubble_b, freeze_b}, {27'd0, exp_b});
    check("stall_count_a", 32'(stall_count_a), 32'(cnt_a));
    check("stall_count_b", 32'(stall_count_b), 32'(cnt_b));
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_Rn = 5'd0; id_Rm = 5'd0; id_Rd = 5'd0; ex_Rd = 5'd0;
    id_uses_rn = 1'b0; id_uses_rm = 1'b0; id_uses_rd = 1'b0;
    ex_mem_read = 1'b0; br_taken = 1'b0; mem_busy = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step(); step();
    #1;
    check("reset_ctrl", {27'd0, pc_write_a, if_id_write_a, flush_a, bubble_a, freeze_a}, 32'h06);
    check("reset_cnt", 32'(stall_count_a), 32'd0);
    reset = 1'b1;
    step(); step();

    // Load-use: LDUR X7 in EX, ADD X1,X7,X2 in ID.
    ex_mem_read = 1'b1; ex_Rd = 5'd7; id_Rn = 5'd7; id_uses_rn = 1'b1; id_Rm = 5'd2; id_uses_rm = 1'b1;
    #1;
    check("lu_pc_write", 32'(pc_write_a), 32'd0);
    check("lu_if_id_write", 32'(if_id_write_a), 32'd0);
    check("lu_bubble", 32'(bubble_a), 32'd1);
    check("lu_cnt_before", 32'(stall_count_a), 32'd0);
    step();
    ex_mem_read = 1'b0;   // the load has moved on
    #1;
    check("lu_pc_write_after", 32'(pc_write_a), 32'd1);
    check("lu_cnt_after", 32'(stall_count_a), 32'd1);
    step();

    // Hazard via Rd/Rt source (store data).
    idle(); ex_mem_read = 1'b1; ex_Rd = 5'd12; id_Rd = 5'd12; id_uses_rd = 1'b1;
    #1;
    check("lu_rd_bubble", 32'(bubble_b), 32'd1);
    step();

    // XZR never hazards.
    idle(); ex_mem_read = 1'b1; ex_Rd = 5'd31; id_Rn = 5'd31; id_uses_rn = 1'b1;
    id_Rm = 5'd31; id_uses_rm = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("xzr_pc_write", 32'(pc_write_a), 32'd1);
      step();
    end
    idle();
    step();

    // Taken branch, FLUSH_CYCLES=2 on dut_a.
    br_taken = 1'b1;
    #1;
    check("br_flush_c0", 32'(flush_a), 32'd1);
    check("br_pc_c0", 32'(pc_write_a), 32'd1);
    step();
    br_taken = 1'b0;
    #1;
    check("br_flush_c1", 32'(flush_a), 32'd1);
    check("br_pc_c1", 32'(pc_write_a), 32'd1);
    step();
    #1;
    check("br_flush_c2", 32'(flush_a), 32'd0);
    check("br_flush_b_c2", 32'(flush_b), 32'd1);
    step(); step();

    // Simultaneous load-use and branch: stall first, branch next cycle.
    ex_mem_read = 1'b1; ex_Rd = 5'd3; id_Rm = 5'd3; id_uses_rm = 1'b1; br_taken = 1'b1;
    #1;
    check("lubr_bubble", 32'(bubble_a), 32'd1);
    check("lubr_flush", 32'(flush_a), 32'd0);
    check("lubr_pc", 32'(pc_write_a), 32'd0);
    step();
    ex_mem_read = 1'b0;
    #1;
    check("lubr_next_flush", 32'(flush_a), 32'd1);
    check("lubr_next_bubble", 32'(bubble_a), 32'd0);
    step();
    idle();
    step(); step(); step();

    // mem_busy during FLUSH on dut_b (FLUSH_CYCLES=3, counter=1 when busy).
    br_taken = 1'b1;
    #1;
    check("mf_flush_c0", 32'(flush_b), 32'd1);
    step();
    br_taken = 1'b0;
    #1;
    check("mf_flush_c1", 32'(flush_b), 32'd1);
    step();
    mem_busy = 1'b1;
    sc0 = int'(stall_count_a);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("mf_freeze", 32'(freeze_b), 32'd1);
      check("mf_noflush", 32'(flush_b), 32'd0);
      check("mf_pc", 32'(pc_write_b), 32'd0);
      step();
    end
    mem_busy = 1'b0;
    #1;
    check("mf_resume_flush", 32'(flush_b), 32'd1);
    check("mf_resume_freeze", 32'(freeze_b), 32'd0);
    check("mf_cnt_plus3", 32'(stall_count_a), 32'(sc0 + 3));
    step();
    #1;
    check("mf_run", 32'(flush_b), 32'd0);
    step();

    // Long freeze saturates dut_b's 3-bit counter, then async reset mid-FREEZE.
    mem_busy = 1'b1;
    sc0 = int'(stall_count_a);
    for (int i = 0; i < 10; i++) step();
    check("sat_cnt_b", 32'(stall_count_b), 32'd7);
    check("freeze_cnt_a", 32'(stall_count_a), 32'(sc0 + 10));
    #2;
    reset = 1'b0;
    #1;
    check("rst_mid_ctrl", {27'd0, pc_write_a, if_id_write_a, flush_a, bubble_a, freeze_a}, 32'h06);
    check("rst_mid_cnt_a", 32'(stall_count_a), 32'd0);
    check("rst_mid_cnt_b", 32'(stall_count_b), 32'd0);
    mem_busy = 1'b0;
    step(); step();
    reset = 1'b1;
    #1;
    check("rst_rel_pc", 32'(pc_write_b), 32'd1);
    check("rst_rel_freeze", 32'(freeze_b), 32'd0);
    check("rst_rel_flush", 32'(flush_b), 32'd0);
    step();

    // Mixed sweep over a small register set, model-checked each cycle.
    for (int i = 0; i < 60; i++) begin
      logic [4:0] regs [5];
      regs = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd31};
      id_Rn = regs[$urandom_range(0, 4)];
      id_Rm = regs[$urandom_range(0, 4)];
      id_Rd = regs[$urandom_range(0, 4)];
      ex_Rd = regs[$urandom_range(0, 4)];
      id_uses_rn  = 1'($urandom_range(0, 1));
      id_uses_rm  = 1'($urandom_range(0, 1));
      id_uses_rd  = 1'($urandom_range(0, 1));
      ex_mem_read = 1'($urandom_range(0, 1));
      br_taken    = ($urandom_range(0, 3) == 0);
      mem_busy    = ($urandom_range(0, 4) == 0);
      step();
    end
    idle();
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_id_hazard_ctrl.md
Name: if_id_hazard_ctrl

Overview:
- Pipeline-control block that sequences the IF/ID register and the PC.
- Detects load-use hazards against the instruction in ID, resolves taken-branch flushes, and freezes the pipe while data memory is busy.
- Drives PC write-enable, IF/ID write-enable, the IF_ID_flush input of the IF/ID register, and the ID/EX bubble select.
- Sits between the ID-stage decode, the EX-stage control bits and the data-memory handshake.

Parameters:
FLUSH_CYCLES, 1, number of consecutive cycles IF_ID_flush is held after a taken branch (1..7)
CNT_W, 16, width of the saturating stall-cycle counter

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous reset, active-low
id_Rn  input  5  Rn field of the instruction in ID
id_Rm  input  5  Rm field of the instruction in ID
id_Rd  input  5  Rd/Rt field of the instruction in ID (source for STUR/CBZ)
id_uses_rn  input  1  ID instruction reads Rn
id_uses_rm  input  1  ID instruction reads Rm
id_uses_rd  input  1  ID instruction reads Rd/Rt as a source
ex_mem_read  input  1  instruction in EX is a load
ex_Rd  input  5  destination register of the instruction in EX
br_taken  input  1  branch resolved taken in ID this cycle
mem_busy  input  1  data memory has not completed its access
pc_write  output  1  PC update enable
if_id_write  output  1  IF/ID load enable (0 = hold)
IF_ID_flush  output  1  synchronous clear of IF/ID at the next rising edge
id_ex_bubble  output  1  force ID/EX control bits to zero
pipe_freeze  output  1  hold ID/EX, EX/MEM and MEM/WB
stall_count  output  CNT_W  saturating count of cycles with pc_write=0

Behaviour:
- Reset, asserted asynchronously: state=RUN, flush counter=0, stall_count=0. While reset is low, outputs are pc_write=0, if_id_write=0, IF_ID_flush=1, id_ex_bubble=1 and pipe_freeze=0.
- load_use (combinational) = ex_mem_read & (ex_Rd!=31) & ((id_uses_rn & ex_Rd==id_Rn) | (id_uses_rm & ex_Rd==id_Rm) | (id_uses_rd & ex_Rd==id_Rd)). X31 never hazards.
- States: RUN, FLUSH, FREEZE. All outputs are combinational from the state and the current inputs, which gives 0-cycle response.
- Priority within a cycle: mem_busy > load_use > br_taken. A branch is not qualified while load_use=1, because its operand is not yet valid.
- RUN, mem_busy=1: pipe_freeze=1, pc_write=0, if_id_write=0, IF_ID_flush=0, id_ex_bubble=0. Next state FREEZE.
- RUN, load_use=1: pc_write=0, if_id_write=0, id_ex_bubble=1, IF_ID_flush=0. Stay in RUN. The stall lasts exactly 1 cycle because the load leaves EX.
- RUN, br_taken=1: pc_write=1, if_id_write=1, IF_ID_flush=1. If FLUSH_CYCLES>1, go to FLUSH with counter=FLUSH_CYCLES-1; otherwise stay in RUN.
- RUN, otherwise: pc_write=1, if_id_write=1, all other outputs 0.
- FLUSH: IF_ID_flush=1, pc_write=1, if_id_write=1. Counter decrements each cycle; return to RUN when the counter reaches 0. br_taken and load_use are ignored, since ID holds a bubble.
  - mem_busy in FLUSH: behave as FREEZE but keep the counter value, and resume FLUSH afterwards. A 2-bit return-state register records this.
- FREEZE: freeze outputs as in RUN/mem_busy. On the first cycle with mem_busy=0, return to the saved state and evaluate that state's rules in the same cycle.
- stall_count increments in every cycle with pc_write=0 outside reset. It saturates at all-ones and does not wrap.
- Reset mid-FLUSH or mid-FREEZE aborts immediately. There is no pending-flush memory.

Decomposition:
- Shared package pipe_ctrl_pkg: state enum (RUN, FLUSH, FREEZE), constant XZR=5'd31, and the FLUSH_CYCLES bound check.
- Sub-module hazard_detect: purely combinational load_use comparator, reusable by a later forwarding unit.
- Remaining logic (FSM, flush counter, stall counter) is in the top module.

Test Plan:
- Load-use: EX is LDUR X7 (ex_mem_read=1, ex_Rd=7); ID is ADD X1,X7,X2 (id_Rn=7, id_uses_rn=1).
  - Required: exactly 1 cycle with pc_write=0, if_id_write=0, id_ex_bubble=1; stall_count 0->1.
- XZR: ex_Rd=31, id_Rn=31, ex_mem_read=1 -> no stall; pc_write=1 throughout.
- Branch with FLUSH_CYCLES=2: br_taken pulsed 1 cycle in RUN.
  - Required: IF_ID_flush=1 for 2 consecutive cycles; pc_write stays 1; back in RUN on the 3rd cycle.
- Simultaneous load_use and br_taken -> stall only (id_ex_bubble=1, IF_ID_flush=0); the branch is honoured on the next cycle when re-presented.
- mem_busy held 3 cycles during FLUSH (FLUSH_CYCLES=3, counter=1).
  - Required: pipe_freeze=1 and IF_ID_flush=0 for 3 cycles, then 1 flush cycle, then RUN; stall_count +3.
- Reset asserted asynchronously mid-FREEZE -> outputs go to reset values before the next edge; stall_count=0; RUN after release.
